// File: rtl/vec_mat_accel_pkg.sv
// Shared opcodes, FSM state codes and sizing helper for the vector/matrix accelerator.
package vec_mat_accel_pkg;

  localparam logic [3:0] OP_READ  = 4'b1000;
  localparam logic [3:0] OP_WRITE = 4'b1001;
  localparam logic [3:0] OP_MMUL  = 4'b1111;

  // ALU opcodes are {1'b0, scalar, alu_op[1:0]}
  localparam int         OP_SCALAR_BIT = 2;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_RSV = 2'b11;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ_RESP = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_ALU       = 3'd3;
  localparam logic [2:0] S_MMUL      = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_mat_regfile.sv
// Vector register file: two combinational read ports, one write port, cleared on reset.
// Out-of-range addresses read as zero and are never written.
module vec_mat_regfile #(
  parameter int els_p   = 12,
  parameter int width_p = 32,
  parameter int aw_p    = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [aw_p-1:0]    ra_addr_i,
  output logic [width_p-1:0] ra_data_o,
  input  logic [aw_p-1:0]    rb_addr_i,
  output logic [width_p-1:0] rb_data_o,
  input  logic               w_v_i,
  input  logic [aw_p-1:0]    w_addr_i,
  input  logic [width_p-1:0] w_data_i
);

  logic [width_p-1:0] mem_q [els_p];

  assign ra_data_o = (int'(ra_addr_i) < els_p) ? mem_q[ra_addr_i] : '0;
  assign rb_data_o = (int'(rb_addr_i) < els_p) ? mem_q[rb_addr_i] : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
    end else if (w_v_i && (int'(w_addr_i) < els_p)) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

endmodule

// File: rtl/vec_mat_accel_top.sv
// Vector/matrix accelerator: read/write/element-wise ALU/matrix multiply on a vector register file,
// one command at a time (ready_o only when idle). Optional VMA_ASSERT_EN enables simulation checks.
module vec_mat_accel_top
  import vec_mat_accel_pkg::*;
#(
  parameter int els_p   = 12,
  parameter int vlen_p  = 4,
  parameter int vdw_p   = 8,
  parameter int lanes_p = 4,
  localparam int aw     = safe_clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [3:0]              op_i,
  input  logic [aw-1:0]           addrA_i,
  input  logic [aw-1:0]           addrB_i,
  input  logic [aw-1:0]           addrD_i,
  input  logic [vdw_p-1:0]        scalar_i,
  input  logic [vlen_p*vdw_p-1:0] w_data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic [vlen_p*vdw_p-1:0] r_data_o,
  output logic                    v_o,
  input  logic                    yumi_i
);

  localparam int w     = vlen_p * vdw_p;
  localparam int beats = vlen_p / lanes_p;
  localparam int bw    = safe_clog2(beats);
  localparam int cw    = safe_clog2(vlen_p);

  logic [2:0]       state_q;
  logic [1:0]       alu_op_q;
  logic             scal_q;
  logic [vdw_p-1:0] scalar_q;
  logic [aw-1:0]    a_q, b_q, d_q;
  logic [bw-1:0]    beat_q;
  logic [cw-1:0]    col_q, row_q;
  logic [w-1:0]     res_q;
  logic [vdw_p-1:0] acc_q;
  logic [w-1:0]     r_data_q;
  logic [w-1:0]     snap_a [vlen_p];
  logic [w-1:0]     snap_b [vlen_p];

  logic [aw-1:0]    ra_addr, rb_addr, wa;
  logic [w-1:0]     rd_a, rd_b, wd;
  logic             we;

  logic             beat_last, col_last, row_last;
  logic [w-1:0]     alu_next, row_next, a_vec, b_vec;
  logic [vdw_p-1:0] x, y, z, part, elem;

  function automatic int elem_sh(input int idx);
    return (vlen_p - 1 - idx) * vdw_p;
  endfunction

  assign beat_last = (beat_q == bw'(beats - 1));
  assign col_last  = (col_q == cw'(vlen_p - 1));
  assign row_last  = (row_q == cw'(vlen_p - 1));

  assign ready_o  = (state_q == S_IDLE);
  assign v_o      = (state_q == S_READ_RESP);
  assign done_o   = (state_q == S_WRITE) || (state_q == S_DONE) || (v_o && yumi_i);
  assign r_data_o = r_data_q;

  vec_mat_regfile #(.els_p(els_p), .width_p(w), .aw_p(aw)) u_rf (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .ra_addr_i (ra_addr),
    .ra_data_o (rd_a),
    .rb_addr_i (rb_addr),
    .rb_data_o (rd_b),
    .w_v_i     (we),
    .w_addr_i  (wa),
    .w_data_i  (wd)
  );

  // Matrix operands are walked column by column; row 0 reads them live and snapshots them.
  always_comb begin
    ra_addr = a_q;
    rb_addr = b_q;
    if (state_q == S_IDLE) begin
      ra_addr = addrA_i;
    end else if (state_q == S_MMUL) begin
      ra_addr = a_q + aw'(col_q);
      rb_addr = b_q + aw'(col_q);
    end
  end

  always_comb begin
    alu_next = res_q;
    x = '0;
    y = '0;
    z = '0;
    for (int l = 0; l < lanes_p; l++) begin
      x = rd_a[elem_sh(int'(beat_q) * lanes_p + l) +: vdw_p];
      y = scal_q ? scalar_q : rd_b[elem_sh(int'(beat_q) * lanes_p + l) +: vdw_p];
      case (alu_op_q)
        ALU_ADD: z = x + y;
        ALU_SUB: z = x - y;
        default: z = x * y;
      endcase
      alu_next[elem_sh(int'(beat_q) * lanes_p + l) +: vdw_p] = z;
    end
  end

  // Later rows use snapshots so rows already written back cannot feed later products.
  always_comb begin
    a_vec = snap_a[row_q];
    if (row_q == '0 && col_q == '0) a_vec = rd_a;
    b_vec = (row_q == '0) ? rd_b : snap_b[col_q];
    part = '0;
    for (int l = 0; l < lanes_p; l++) begin
      part = part + a_vec[elem_sh(int'(beat_q) * lanes_p + l) +: vdw_p]
                  * b_vec[elem_sh(int'(beat_q) * lanes_p + l) +: vdw_p];
    end
    elem = acc_q + part;
    row_next = res_q;
    row_next[elem_sh(int'(col_q)) +: vdw_p] = elem;
  end

  always_comb begin
    we = 1'b0;
    wa = d_q;
    wd = alu_next;
    if (state_q == S_IDLE && v_i && op_i == OP_WRITE) begin
      we = 1'b1;
      wa = addrD_i;
      wd = w_data_i;
    end else if (state_q == S_ALU && beat_last) begin
      we = 1'b1;
    end else if (state_q == S_MMUL && beat_last && col_last) begin
      we = 1'b1;
      wa = d_q + aw'(row_q);
      wd = row_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_MMUL && row_q == '0) begin
      snap_a[col_q] <= rd_a;
      snap_b[col_q] <= rd_b;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      alu_op_q <= ALU_ADD;
      scal_q   <= 1'b0;
      scalar_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      beat_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      res_q    <= '0;
      acc_q    <= '0;
      r_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (v_i) begin
          alu_op_q <= op_i[1:0];
          scal_q   <= op_i[OP_SCALAR_BIT];
          scalar_q <= scalar_i;
          a_q      <= addrA_i;
          b_q      <= addrB_i;
          d_q      <= addrD_i;
          beat_q   <= '0;
          col_q    <= '0;
          row_q    <= '0;
          res_q    <= '0;
          acc_q    <= '0;
          if (op_i == OP_READ) begin
            r_data_q <= rd_a;
            state_q  <= S_READ_RESP;
          end else if (op_i == OP_WRITE) begin
            state_q <= S_WRITE;
          end else if (op_i == OP_MMUL) begin
            state_q <= S_MMUL;
          end else if (!op_i[3] && op_i[1:0] != ALU_RSV) begin
            state_q <= S_ALU;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_READ_RESP: if (yumi_i) state_q <= S_IDLE;
        S_ALU: begin
          res_q  <= alu_next;
          beat_q <= beat_q + 1'b1;
          if (beat_last) state_q <= S_DONE;
        end
        S_MMUL: begin
          if (beat_last) begin
            beat_q <= '0;
            acc_q  <= '0;
            res_q  <= row_next;
            if (col_last) begin
              col_q <= '0;
              if (row_last) state_q <= S_DONE;
              else          row_q   <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end else begin
            beat_q <= beat_q + 1'b1;
            acc_q  <= elem;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef VMA_ASSERT_EN
  if (vlen_p % lanes_p != 0) begin : g_lane_chk
    $error("vec_mat_accel_top: vlen_p must be a multiple of lanes_p");
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (v_i && !ready_o) $error("vec_mat_accel_top: command while busy");
      if (yumi_i && !v_o) $error("vec_mat_accel_top: yumi_i without v_o");
      if (we && int'(wa) >= els_p) $error("vec_mat_accel_top: write address out of range");
      if (((state_q == S_IDLE && v_i && op_i == OP_READ) || state_q == S_ALU ||
           (state_q == S_MMUL && row_q == '0)) && int'(ra_addr) >= els_p)
        $error("vec_mat_accel_top: read address A out of range");
      if (((state_q == S_ALU && !scal_q) || (state_q == S_MMUL && row_q == '0)) &&
          int'(rb_addr) >= els_p)
        $error("vec_mat_accel_top: read address B out of range");
    end
  end
`else
  // range and protocol checks are compiled out
`endif

endmodule

// File: tb/tb_vec_mat_accel_top.sv
// Directed self-checking bench for vec_mat_accel_top with default parameters.
module tb_vec_mat_accel_top;

  localparam logic [3:0] T_READ  = 4'b1000;
  localparam logic [3:0] T_WRITE = 4'b1001;
  localparam logic [3:0] T_MMUL  = 4'b1111;
  localparam logic [3:0] T_ADD   = 4'b0000;
  localparam logic [3:0] T_SUB   = 4'b0001;
  localparam logic [3:0] T_SMUL  = 4'b0110;
  localparam logic [3:0] T_RSV   = 4'b1010;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [3:0]  op_i;
  logic [3:0]  addrA_i, addrB_i, addrD_i;
  logic [7:0]  scalar_i;
  logic [31:0] w_data_i;
  logic        v_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] r_data_o;
  logic        v_o;
  logic        yumi_i;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;
  int ndone;
  int dcyc;

  vec_mat_accel_top dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .op_i     (op_i),
    .addrA_i  (addrA_i),
    .addrB_i  (addrB_i),
    .addrD_i  (addrD_i),
    .scalar_i (scalar_i),
    .w_data_i (w_data_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .r_data_o (r_data_o),
    .v_o      (v_o),
    .yumi_i   (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] d, input logic [7:0] s, input logic [31:0] wd);
    op_i = op; addrA_i = a; addrB_i = b; addrD_i = d; scalar_i = s; w_data_i = wd;
    v_i = 1'b1;
    tick();
    v_i = 1'b0;
  endtask

  // Returns the cycle (accept = 0) in which done_o is seen; gives up after 40 cycles.
  task automatic wait_done(output int c);
    c = 1;
    while (!done_o && c < 40) begin
      tick();
      c++;
    end
  endtask

  task automatic wr(input logic [3:0] d, input logic [31:0] data);
    int c;
    send(T_WRITE, 4'd0, 4'd0, d, 8'd0, data);
    wait_done(c);
    tick();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    send(T_READ, a, 4'd0, 4'd0, 8'd0, 32'd0);
    chk({tag, "_v"}, {31'd0, v_o}, 32'd1);
    chk(tag, r_data_o, exp);
    yumi_i = 1'b1;
    #1;
    chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
    tick();
    yumi_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; op_i = 4'd0;
    addrA_i = 4'd0; addrB_i = 4'd0; addrD_i = 4'd0; scalar_i = 8'd0; w_data_i = 32'd0;
    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_v", {31'd0, v_o}, 32'd0);
    chk("rst_rdata", r_data_o, 32'd0);

    // write then read with held response
    send(T_WRITE, 4'd0, 4'd0, 4'd3, 8'd0, 32'h01020201);
    chk("wr_busy", {31'd0, ready_o}, 32'd0);
    wait_done(cyc);
    chk("wr_lat", cyc, 32'd1);
    tick();
    chk("wr_idle", {31'd0, ready_o}, 32'd1);

    send(T_READ, 4'd3, 4'd0, 4'd0, 8'd0, 32'd0);
    chk("rd3_v", {31'd0, v_o}, 32'd1);
    chk("rd3_data", r_data_o, 32'h01020201);
    chk("rd3_nodone", {31'd0, done_o}, 32'd0);
    tick();
    tick();
    chk("rd3_hold_v", {31'd0, v_o}, 32'd1);
    chk("rd3_hold_nodone", {31'd0, done_o}, 32'd0);
    yumi_i = 1'b1;
    #1;
    chk("rd3_done", {31'd0, done_o}, 32'd1);
    tick();
    yumi_i = 1'b0;
    chk("rd3_v_drop", {31'd0, v_o}, 32'd0);
    chk("rd3_idle", {31'd0, ready_o}, 32'd1);
    chk("rd3_data_held", r_data_o, 32'h01020201);

    wr(4'd0, 32'h01010101); wr(4'd1, 32'h01020102);
    wr(4'd2, 32'h02010201); wr(4'd3, 32'h01020201);
    wr(4'd4, 32'h01030301); wr(4'd5, 32'h03020102);
    wr(4'd6, 32'h01020103); wr(4'd7, 32'h03010101);

    // element-wise ALU
    send(T_ADD, 4'd0, 4'd1, 4'd8, 8'd0, 32'd0);
    wait_done(cyc);
    chk("add_lat", cyc, 32'd2);
    tick();
    rd(4'd8, 32'h02030203, "add");

    send(T_SUB, 4'd0, 4'd1, 4'd9, 8'd0, 32'd0);
    wait_done(cyc);
    chk("sub_lat", cyc, 32'd2);
    tick();
    rd(4'd9, 32'h00FF00FF, "sub");

    send(T_SMUL, 4'd1, 4'd0, 4'd10, 8'd3, 32'd0);
    wait_done(cyc);
    chk("smul_lat", cyc, 32'd2);
    tick();
    rd(4'd10, 32'h03060306, "smul");

    // reserved opcode and out-of-range address
    send(T_RSV, 4'd0, 4'd0, 4'd0, 8'd0, 32'd0);
    wait_done(cyc);
    chk("rsv_lat", cyc, 32'd1);
    tick();
    wr(4'd12, 32'hAABBCCDD);
    rd(4'd12, 32'd0, "oob");

    // matrix multiply with commands offered while busy
    send(T_MMUL, 4'd0, 4'd4, 4'd8, 8'd0, 32'd0);
    chk("mmul_busy", {31'd0, ready_o}, 32'd0);
    ndone = 0;
    dcyc = 0;
    for (int c = 1; c <= 25; c++) begin
      if (done_o) begin
        ndone++;
        dcyc = c;
      end
      if (c >= 2 && c <= 5) begin
        op_i = T_WRITE; addrD_i = 4'd7; w_data_i = 32'hFFFFFFFF; v_i = 1'b1;
      end else begin
        v_i = 1'b0;
      end
      tick();
    end
    chk("mmul_ndone", ndone, 32'd1);
    chk("mmul_lat", dcyc, 32'd17);
    rd(4'd8,  32'h08080706, "mmul_r0");
    rd(4'd9,  32'h0C0C0C08, "mmul_r1");
    rd(4'd10, 32'h0C0C090A, "mmul_r2");
    rd(4'd11, 32'h0E0B0A08, "mmul_r3");
    rd(4'd7,  32'h03010101, "busy_ignored");

    // reset in the middle of a matrix multiply
    send(T_MMUL, 4'd0, 4'd4, 4'd8, 8'd0, 32'd0);
    repeat (5) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("mrst_ready", {31'd0, ready_o}, 32'd1);
    chk("mrst_done", {31'd0, done_o}, 32'd0);
    chk("mrst_v", {31'd0, v_o}, 32'd0);
    chk("mrst_rdata", r_data_o, 32'd0);
    rd(4'd0, 32'd0, "mrst_cleared");
    wr(4'd5, 32'h12345678);
    rd(4'd5, 32'h12345678, "mrst_wr_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
